// File: rtl/sum_differ_if.sv
// Stream bundle for sum_differ: running-sum input and difference output.
interface sum_differ_if #(parameter int WIDTH = 32);
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] s_sum;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_amt;
  logic             m_wrap;

  // slave: the differencer itself; master: whoever feeds it and drains it
  modport slave (
    input  s_valid, s_sum, m_ready,
    output s_ready, m_valid, m_amt, m_wrap
  );
  modport master (
    output s_valid, s_sum, m_ready,
    input  s_ready, m_valid, m_amt, m_wrap
  );
endinterface

// File: rtl/sum_differ.sv
// Differencer that turns an accumulator's running sums back into increments,
// with optional decimation and a 2-entry output buffer.
module sum_differ #(
  parameter int WIDTH      = 32,
  parameter int DECIM      = 1,
  parameter int PRIME_ZERO = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          restart,
  sum_differ_if.slave   bus
);
  localparam int CW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam bit PZ = (PRIME_ZERO != 0);

  typedef enum logic {EMPTY, PRIMED} state_t;
  typedef struct packed {
    logic             wrap;
    logic [WIDTH-1:0] amt;
  } ent_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] hist;
  logic [CW-1:0]    cnt;
  ent_t             mem [2];
  logic             rd_ptr, wr_ptr;
  logic [1:0]       count, count_nx;
  logic             s_ready_q;

  logic accept, out_acc, push, pop, last;
  ent_t ent_in;

  assign last    = (cnt == CW'(DECIM - 1));
  assign accept  = bus.s_valid && s_ready_q && !restart;
  assign out_acc = accept && last;
  // In EMPTY without zero-priming the sample only seeds history.
  assign push    = out_acc && (state == PRIMED || PZ);
  assign pop     = bus.m_valid && bus.m_ready;

  assign ent_in.amt  = bus.s_sum - hist;
  assign ent_in.wrap = (bus.s_sum < hist);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= EMPTY;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (restart)      state_nx = EMPTY;
    else if (out_acc) state_nx = PRIMED;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist <= '0;
      cnt  <= '0;
    end else if (restart) begin
      hist <= '0;
      cnt  <= '0;
    end else if (accept) begin
      if (last) begin
        hist <= bus.s_sum;
        cnt  <= '0;
      end else begin
        cnt  <= cnt + CW'(1);
      end
    end
  end

  always_comb begin
    count_nx = count;
    case ({push, pop})
      2'b10:   count_nx = count + 2'd1;
      2'b01:   count_nx = count - 2'd1;
      default: count_nx = count;
    endcase
  end

  // s_ready is registered from the post-update occupancy, so it drops
  // in the same edge that fills the buffer and a full buffer is never pushed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem[0]    <= '0;
      mem[1]    <= '0;
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      count     <= 2'd0;
      s_ready_q <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= ent_in;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count     <= count_nx;
      s_ready_q <= (count_nx <= 2'd1);
    end
  end

  assign bus.s_ready = s_ready_q;
  assign bus.m_valid = (count != 2'd0);
  assign bus.m_amt   = mem[rd_ptr].amt;
  assign bus.m_wrap  = mem[rd_ptr].wrap;
endmodule

// File: tb/tb_sum_differ.sv
// Directed bench for sum_differ: three parameterizations, queue scoreboards.
module tb_sum_differ;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic restart = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [32:0] q0[$], q1[$], q2[$];   // {wrap, amt}

  sum_differ_if #(.WIDTH(32)) i0 ();
  sum_differ_if #(.WIDTH(32)) i1 ();
  sum_differ_if #(.WIDTH(32)) i2 ();

  sum_differ #(.WIDTH(32), .DECIM(1), .PRIME_ZERO(1)) u0 (.clk(clk), .reset(reset), .restart(restart), .bus(i0));
  sum_differ #(.WIDTH(32), .DECIM(1), .PRIME_ZERO(0)) u1 (.clk(clk), .reset(reset), .restart(restart), .bus(i1));
  sum_differ #(.WIDTH(32), .DECIM(3), .PRIME_ZERO(1)) u2 (.clk(clk), .reset(reset), .restart(restart), .bus(i2));

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(int d, logic v, logic [31:0] s);
    case (d)
      0: begin i0.s_valid = v; i0.s_sum = s; end
      1: begin i1.s_valid = v; i1.s_sum = s; end
      default: begin i2.s_valid = v; i2.s_sum = s; end
    endcase
  endtask

  function automatic logic rdy(int d);
    case (d)
      0: return i0.s_ready;
      1: return i1.s_ready;
      default: return i2.s_ready;
    endcase
  endfunction

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(int d, logic [31:0] v);
    int n = 0;
    set_in(d, 1'b1, v);
    @(negedge clk);
    while (!rdy(d) && n < 50) begin @(negedge clk); n++; end
    if (!rdy(d)) chk("send_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    set_in(d, 1'b0, '0);
  endtask

  task automatic pulse_restart(int d);
    restart = 1'b1;
    set_in(d, 1'b1, 32'd99);
    @(posedge clk); #1;
    restart = 1'b0;
    set_in(d, 1'b0, '0);
  endtask

  task automatic drain();
    int n = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("drain", 64'(q0.size() + q1.size() + q2.size()), 64'd0);
  endtask

  always @(negedge clk) if (reset && i0.m_valid && i0.m_ready) begin
    if (q0.size() == 0) chk("u0_unexpected", {31'd0, i0.m_wrap, i0.m_amt}, 64'h1_0000_0000_0000);
    else chk("u0_out", {31'd0, i0.m_wrap, i0.m_amt}, {31'd0, q0.pop_front()});
  end
  always @(negedge clk) if (reset && i1.m_valid && i1.m_ready) begin
    if (q1.size() == 0) chk("u1_unexpected", {31'd0, i1.m_wrap, i1.m_amt}, 64'h1_0000_0000_0000);
    else chk("u1_out", {31'd0, i1.m_wrap, i1.m_amt}, {31'd0, q1.pop_front()});
  end
  always @(negedge clk) if (reset && i2.m_valid && i2.m_ready) begin
    if (q2.size() == 0) chk("u2_unexpected", {31'd0, i2.m_wrap, i2.m_amt}, 64'h1_0000_0000_0000);
    else chk("u2_out", {31'd0, i2.m_wrap, i2.m_amt}, {31'd0, q2.pop_front()});
  end

  initial begin
    set_in(0, 1'b0, '0); set_in(1, 1'b0, '0); set_in(2, 1'b0, '0);
    i0.m_ready = 1'b1; i1.m_ready = 1'b1; i2.m_ready = 1'b1;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_s_ready", 64'(i0.s_ready), 64'd0);
    chk("rst_m_valid", 64'(i0.m_valid), 64'd0);
    chk("rst_m_amt",   64'(i0.m_amt),   64'd0);
    chk("rst_m_wrap",  64'(i0.m_wrap),  64'd0);
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 64'(i0.s_ready), 64'd1);
    @(posedge clk); #1;

    // 1,2,3 back to back, one-cycle latency
    q0.push_back({1'b0, 32'd1}); q0.push_back({1'b0, 32'd1}); q0.push_back({1'b0, 32'd1});
    send(0, 32'd1);
    chk("lat_m_valid", 64'(i0.m_valid), 64'd1);
    chk("lat_m_amt",   64'(i0.m_amt),   64'd1);
    send(0, 32'd2);
    send(0, 32'd3);

    // wrap: hist=3
    q0.push_back({1'b0, 32'hFFFF_FFFB}); q0.push_back({1'b1, 32'd3});
    send(0, 32'hFFFF_FFFE);
    send(0, 32'h0000_0001);
    drain();

    // backpressure
    pulse_restart(0);
    i0.m_ready = 1'b0;
    q0.push_back({1'b0, 32'd2}); q0.push_back({1'b0, 32'd2}); q0.push_back({1'b0, 32'd2});
    send(0, 32'd2);
    send(0, 32'd4);
    chk("bp_full_ready", 64'(i0.s_ready), 64'd0);
    set_in(0, 1'b1, 32'd6);
    repeat (3) @(negedge clk);
    chk("bp_hold_ready", 64'(i0.s_ready), 64'd0);
    chk("bp_hold_valid", 64'(i0.m_valid), 64'd1);
    chk("bp_hold_amt",   64'(i0.m_amt),   64'd2);
    @(posedge clk); #1;
    i0.m_ready = 1'b1;
    send(0, 32'd6);
    drain();

    // restart mid-stream; pending output survives, sample in restart cycle dropped
    pulse_restart(0);
    i0.m_ready = 1'b0;
    q0.push_back({1'b0, 32'd10}); q0.push_back({1'b0, 32'd12});
    send(0, 32'd10);
    pulse_restart(0);
    chk("rs_pending_valid", 64'(i0.m_valid), 64'd1);
    chk("rs_pending_amt",   64'(i0.m_amt),   64'd10);
    i0.m_ready = 1'b1;
    send(0, 32'd12);
    drain();

    // PRIME_ZERO=0: 5,8,8 -> 3,0
    q1.push_back({1'b0, 32'd3}); q1.push_back({1'b0, 32'd0});
    send(1, 32'd5);
    chk("p0_no_first", 64'(i1.m_valid), 64'd0);
    send(1, 32'd8);
    send(1, 32'd8);
    drain();

    // DECIM=3: 1..6 -> 3,3
    q2.push_back({1'b0, 32'd3}); q2.push_back({1'b0, 32'd3});
    for (int k = 1; k <= 6; k++) send(2, 32'(k));
    drain();

    // async reset mid-stream flushes the buffer
    i0.m_ready = 1'b0;
    send(0, 32'd7);
    chk("pre_ar_valid", 64'(i0.m_valid), 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("ar_m_valid", 64'(i0.m_valid), 64'd0);
    chk("ar_s_ready", 64'(i0.s_ready), 64'd0);
    chk("ar_m_amt",   64'(i0.m_amt),   64'd0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    i0.m_ready = 1'b1;
    chk("ar_ready_back", 64'(i0.s_ready), 64'd1);
    q0.push_back({1'b0, 32'd4});
    send(0, 32'd4);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
